// File: rtl/gpio_debouncer.sv
// Per-bit glitch filter with AXI4-Stream change-event reporting.
// Build option: define GPIO_DEBOUNCER_COALESCE_EN to merge colliding events instead of dropping them.
module gpio_debouncer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNTR_WIDTH = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [CNTR_WIDTH-1:0]   cfg_data,
   input  logic [DATA_WIDTH-1:0]   din,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    overflow
);

   logic [CNTR_WIDTH-1:0] cnt      [DATA_WIDTH];
   logic [CNTR_WIDTH-1:0] cnt_next [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] chg;
   logic [DATA_WIDTH-1:0] dout_next;
   logic                  handshake;
   logic                  collision;

   // A bit is accepted once it has disagreed with dout for cfg_data+1 samples.
   // The >= test also lets a lowered cfg_data release a long-running count at once.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      dout_next = dout;
      chg       = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         cnt_next[i] = '0;
         if (din[i] != dout[i]) begin
            if (cnt[i] >= cfg_data) begin
               chg[i]       = 1'b1;
               dout_next[i] = din[i];
            end else begin
               cnt_next[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   assign handshake = m_axis_tvalid & m_axis_tready;
   assign collision = m_axis_tvalid & ~m_axis_tready & (chg != '0);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         // NOTE: the counter array is small flop storage, not RAM, so it is reset like any other state.
         for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt[i] <= '0;
         end
         dout <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         cnt  <= cnt_next;
         dout <= dout_next;
      end
   end

   // Single-entry event register; tvalid rises on the same edge dout changes.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         overflow      <= 1'b0;
      end else if (chg != '0) begin
         if (!m_axis_tvalid || handshake) begin
            m_axis_tdata  <= {dout_next, chg};
            m_axis_tvalid <= 1'b1;
         end else if (collision) begin
`ifdef GPIO_DEBOUNCER_COALESCE_EN
            m_axis_tdata <= {dout_next, m_axis_tdata[DATA_WIDTH-1:0] | chg};
`else
            overflow <= 1'b1;
`endif
         end
      end else if (handshake) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gpio_debouncer.sv
// Scoreboard bench for gpio_debouncer: a reference model queues expected events,
// a negedge monitor compares dout/tvalid/overflow and pops events on each handshake.
module tb_gpio_debouncer;

   localparam int W  = 8;
   localparam int CW = 16;

   logic          aclk = 1'b0;
   logic          areset;
   logic [CW-1:0] cfg_data;
   logic [W-1:0]  din;
   logic [W-1:0]  dout;
   logic [2*W-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          overflow;

   int errors = 0;
   int checks = 0;

   gpio_debouncer #(.DATA_WIDTH(W), .CNTR_WIDTH(CW)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_data      (cfg_data),
      .din           (din),
      .dout          (dout),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .overflow      (overflow)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: each bit tracks how many consecutive samples it has
   // disagreed with the filtered state; the event slot is a one-deep queue.
   logic [W-1:0]   m_dout;
   int             m_run [W];
   logic           m_pend;
   logic           m_ovf;
   logic [2*W-1:0] exp_q[$];

   always @(posedge aclk or posedge areset) begin
      logic [W-1:0]   c;
      logic [W-1:0]   nd;
      logic [2*W-1:0] last;
      if (areset) begin
         m_dout = '0;
         m_pend = 1'b0;
         m_ovf  = 1'b0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
         exp_q.delete();
      end else begin
         c  = '0;
         nd = m_dout;
         for (int i = 0; i < W; i++) begin
            if (din[i] == m_dout[i]) begin
               m_run[i] = 0;
            end else if (m_run[i] >= int'(cfg_data)) begin
               c[i]     = 1'b1;
               nd[i]    = din[i];
               m_run[i] = 0;
            end else begin
               m_run[i] = m_run[i] + 1;
            end
         end
         if (c != '0) begin
            if (!m_pend || m_axis_tready) begin
               exp_q.push_back({nd, c});
               m_pend = 1'b1;
            end else begin
`ifdef GPIO_DEBOUNCER_COALESCE_EN
               last = exp_q[$];
               exp_q[$] = {nd, last[W-1:0] | c};
`else
               m_ovf = 1'b1;
`endif
            end
         end else if (m_pend && m_axis_tready) begin
            m_pend = 1'b0;
         end
         m_dout = nd;
      end
   end

   always @(negedge aclk) begin
      logic [2*W-1:0] e;
      if (!areset) begin
         check("dout", 32'(dout), 32'(m_dout));
         check("tvalid", 32'(m_axis_tvalid), 32'(m_pend));
         check("overflow", 32'(overflow), 32'(m_ovf));
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", 32'(m_axis_tdata), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("event_tdata", 32'(m_axis_tdata), 32'(e));
            end
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset(input int n);
      @(posedge aclk);
      #1;
      areset   = 1'b1;
      din      = '0;
      cfg_data = CW'(n);
      @(posedge aclk);
      #1;
      areset = 1'b0;
   endtask

   initial begin
      int n;
      areset        = 1'b1;
      din           = '0;
      cfg_data      = '0;
      m_axis_tready = 1'b0;

      // Reset state, then basic rise with N=3
      do_reset(3);
      m_axis_tready = 1'b1;
      check("reset_dout", 32'(dout), 32'h0);
      check("reset_tvalid", 32'(m_axis_tvalid), 32'h0);
      check("reset_tdata", 32'(m_axis_tdata), 32'h0);
      check("reset_overflow", 32'(overflow), 32'h0);
      din = 8'h01;
      repeat (3) tick();
      check("rise_edge3_dout", 32'(dout), 32'h0);
      tick();
      check("rise_edge4_dout", 32'(dout), 32'h01);
      check("rise_edge4_tvalid", 32'(m_axis_tvalid), 32'h1);
      check("rise_edge4_tdata", 32'(m_axis_tdata), 32'h0101);
      tick();
      check("rise_edge5_tvalid", 32'(m_axis_tvalid), 32'h0);

      // Glitch of 3 samples with N=3
      do_reset(3);
      m_axis_tready = 1'b1;
      din = 8'h04;
      repeat (3) tick();
      din = 8'h00;
      repeat (4) tick();
      check("glitch_dout", 32'(dout), 32'h0);
      check("glitch_tvalid", 32'(m_axis_tvalid), 32'h0);
      check("glitch_cnt2", 32'(dut.cnt[2]), 32'h0);

      // Backpressure with N=0
      do_reset(0);
      m_axis_tready = 1'b0;
      din = 8'h01;
      tick();
      check("bp_first_tdata", 32'(m_axis_tdata), 32'h0101);
      din = 8'h03;
      tick();
      tick();
      check("bp_tvalid", 32'(m_axis_tvalid), 32'h1);
`ifdef GPIO_DEBOUNCER_COALESCE_EN
      check("bp_tdata_merged", 32'(m_axis_tdata), 32'h0303);
      check("bp_overflow", 32'(overflow), 32'h0);
`else
      check("bp_tdata_held", 32'(m_axis_tdata), 32'h0101);
      check("bp_overflow", 32'(overflow), 32'h1);
`endif
      m_axis_tready = 1'b1;
      tick();
      check("bp_drained", 32'(m_axis_tvalid), 32'h0);
      tick();
      check("bp_no_second", 32'(m_axis_tvalid), 32'h0);

      // Change and handshake on the same edge
      do_reset(0);
      m_axis_tready = 1'b1;
      din = 8'h02;
      tick();
      check("b2b_first_tdata", 32'(m_axis_tdata), 32'h0202);
      din = 8'h00;
      tick();
      check("b2b_tvalid", 32'(m_axis_tvalid), 32'h1);
      check("b2b_second_tdata", 32'(m_axis_tdata), 32'h0002);
      tick();
      check("b2b_idle", 32'(m_axis_tvalid), 32'h0);

      // Reset while counting and while an event is pending
      do_reset(0);
      m_axis_tready = 1'b0;
      din = 8'h80;
      tick();
      cfg_data = 16'd3;
      din = 8'h81;
      repeat (2) tick();
      check("mid_cnt0", 32'(dut.cnt[0]), 32'h2);
      check("mid_tvalid", 32'(m_axis_tvalid), 32'h1);
      areset = 1'b1;
      #1;
      check("mid_rst_dout", 32'(dout), 32'h0);
      check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'h0);
      check("mid_rst_tdata", 32'(m_axis_tdata), 32'h0);
      check("mid_rst_overflow", 32'(overflow), 32'h0);
      din = 8'h01;
      cfg_data = 16'd1;
      m_axis_tready = 1'b1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      tick();
      check("mid_edge1_tvalid", 32'(m_axis_tvalid), 32'h0);
      tick();
      check("mid_edge2_tvalid", 32'(m_axis_tvalid), 32'h1);
      check("mid_edge2_tdata", 32'(m_axis_tdata), 32'h0101);

      // Randomized traffic with random backpressure
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(0, 4));
         do_reset(n);
         for (int c = 0; c < 500; c++) begin
            din = din ^ W'($urandom & $urandom & $urandom);
            m_axis_tready = ($urandom % 4) != 0;
            tick();
         end
         m_axis_tready = 1'b1;
         repeat (n + 4) tick();
         check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpio_debouncer.md
# gpio_debouncer

Per-bit debouncer and change-event reporter for slow external inputs such as buttons, limit switches and status lines. It sits directly downstream of the two-flop `shift_register` synchronizer, so `din` is already in the `aclk` domain. It filters glitches with a programmable per-bit hold count and drives a registered debounced state. Every accepted change is reported as an AXI4-Stream event for a DMA or CPU FIFO.

## Interface
- `DATA_WIDTH`, 8: number of input bits.
- `CNTR_WIDTH`, 16: width of the per-bit debounce counters and of `cfg_data`.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  reset, asynchronous, active-high.
- `cfg_data`  in  CNTR_WIDTH  debounce length N; quasi-static.
- `din`  in  DATA_WIDTH  inputs, already synchronized to `aclk`.
- `dout`  out  DATA_WIDTH  debounced state, registered.
- `m_axis_tdata`  out  2*DATA_WIDTH  event: [2W-1:W] = debounced state after the event; [W-1:0] = changed-bit mask.
- `m_axis_tvalid`  out  1  event valid.
- `m_axis_tready`  in  1  downstream ready.
- `overflow`  out  1  sticky flag: an event was lost.

## Operation
- Reset values: every `cnt[i]`, `dout`, `m_axis_tdata`, `m_axis_tvalid` and `overflow` is 0.
- Counter rules, evaluated independently for each bit i on every edge:
  - `din[i] == dout[i]`: `cnt[i]` <= 0.
  - `din[i] != dout[i]` and `cnt[i] < cfg_data`: `cnt[i]` <= `cnt[i]`+1.
  - `din[i] != dout[i]` and `cnt[i] >= cfg_data`: accept. `dout[i]` <= `din[i]`, `cnt[i]` <= 0, and `chg[i]` = 1 for this edge.
- A glitch shorter than N+1 samples never reaches `dout`.
- If `cfg_data` is lowered below a running count, the `>=` test accepts the change on the next edge. Counters never exceed `cfg_data` while it is held constant.
- Event output register: the event word is {`dout_next`, `chg`}, where `dout_next` is the value `dout` takes at this edge. On each edge where `chg != 0`:
  - Register empty (`tvalid`=0), or handshake in progress (`tvalid & tready`): load the event word, `tvalid` <= 1.
  - `tvalid & !tready`: the collision is handled as described under Configuration.
- If there is no change and the handshake completes, `tvalid` <= 0.
- `overflow` is cleared only by `areset`.
- After reset, any `din` bit that is 1 produces a rising event once N+1 samples have passed. This is intended: it reports the initial state.

## Timing
- Latency from `din` to `dout` is exactly N+1 rising edges. The first edge that samples the new value counts as edge 1; `dout` updates at edge N+1. With N=0, `dout` follows `din` one cycle later.
- `m_axis_tvalid` rises at the same edge at which `dout` updates. There is no combinational path from `din` or `m_axis_tready` to any output.
- Throughput: one event per cycle when `tready` is held high. A change and a handshake in the same cycle load the new event back-to-back, and `tvalid` stays 1.
- `areset` asserted mid-operation clears all state immediately, including a pending event, which is lost without setting `overflow`.

## Configuration
- `GPIO_DEBOUNCER_COALESCE_EN` defined: a collision (`tvalid & !tready & chg != 0`) merges into the pending event.
  - Mask <= mask | `chg`.
  - State field <= `dout_next`.
  - `overflow` is never set.
  - `tdata` may change while `tvalid` is high, so consumers must sample it on the handshake.
- `GPIO_DEBOUNCER_COALESCE_EN` not defined: on a collision the new event is dropped and `overflow` <= 1.
  - `tdata` stays stable while `tvalid & !tready`, per strict AXI4-Stream.

## Test plan
- Basic rise: N=3, `tready`=1, `din[0]` 0->1 and held. `dout[0]`=1 and `tvalid`=1 for one cycle at the 4th edge, with `tdata`=16'h0101 (W=8).
- Glitch rejection: N=3, `din[2]` high for 3 cycles then low. `dout` stays 0, no `tvalid`, `cnt[2]` returns to 0.
- Backpressure, default build: N=0, `tready`=0, `din` 0x00->0x01->0x03. First event `tdata`=16'h0101 held stable, `overflow`=1, second event absent after `tready`=1.
- Same stimulus with `GPIO_DEBOUNCER_COALESCE_EN` defined: a single event with `tdata`=16'h0303 and `overflow`=0.
- Simultaneous handshake and change: N=0, `tready`=1, `din` toggles bit 1 on consecutive cycles. `tvalid` stays high, the masks are 0x02 and 0x02, and the states are 0x02 then 0x00.
- Reset mid-count and mid-pending: assert `areset` while `cnt[0]`=2 and `tvalid`=1. Outputs are 0 immediately; after release with `din`=0x01, N=1, an event arrives at the 2nd edge.
